// File: rtl/mold_pkg.sv
// Shared types and constants for the MoldUDP64 retransmission-request path.
// Field widths here match the default parameters of mold_rerequest_sched.
package mold_pkg;

   localparam int          MOLD_REQ_BYTES = 20;
   localparam logic [15:0] MOLD_EOS_CNT   = 16'hFFFF;
   localparam int          MOLD_SID_W     = 80;
   localparam int          MOLD_SEQ_W     = 64;

   typedef struct packed {
      logic [MOLD_SID_W-1:0] sid;
      logic [MOLD_SEQ_W-1:0] seq_start;
      logic [MOLD_SEQ_W-1:0] cnt;
   } miss_entry_t;

   typedef enum logic [2:0] {IDLE, LOAD, B0, B1, B2, GAP} req_fsm_t;

   // Big-endian 8-byte group -> AXI lane order (first wire byte in lane 0).
   function automatic logic [63:0] mold_wire_order(input logic [63:0] v);
      logic [63:0] r;
      for (int k = 0; k < 8; k++) r[8*k +: 8] = v[63-8*k -: 8];
      return r;
   endfunction

endpackage

// File: rtl/mold_req_fifo.sv
// Synchronous queue of pending missing-sequence ranges with occupancy and flush.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module mold_req_fifo
   import mold_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_flush,
   input  logic                       i_push,
   input  miss_entry_t                i_data,
   input  logic                       i_pop,
   output miss_entry_t                o_data,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_level
);

   localparam int AW = $clog2(DEPTH);

   miss_entry_t   r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_level;
   logic          w_wr;
   logic          w_rd;

   assign o_full  = (r_level == (AW+1)'(DEPTH));
   assign o_empty = (r_level == '0);
   assign o_level = r_level;
   assign o_data  = r_mem[r_rd_ptr];
   assign w_wr    = i_push & (~o_full | i_pop) & ~i_flush;
   assign w_rd    = i_pop & ~o_empty & ~i_flush;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_wr, w_rd})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/mold_rerequest_sched.sv
// MoldUDP64 re-request scheduler: queues missing ranges, splits them into legal
// 20-byte request packets on a 64-bit AXI-stream, and rate-limits between packets.
module mold_rerequest_sched
   import mold_pkg::*;
#(
   parameter int          AXI_DATA_W  = 64,
   parameter int          AXI_KEEP_W  = 8,
   parameter int          SID_W       = 80,
   parameter int          SEQ_NUM_W   = 64,
   parameter int          ML_W        = 16,
   parameter int          FIFO_DEPTH  = 4,
   parameter logic [15:0] MAX_REQ_CNT = 16'hFFFE,
   parameter int          GAP_W       = 16,
   parameter int          GAP_CYC     = 1024
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          en_i,
   input  logic                          flush_i,
   input  logic                          miss_v_i,
   input  logic [SID_W-1:0]              miss_sid_i,
   input  logic [SEQ_NUM_W-1:0]          miss_seq_start_i,
   input  logic [SEQ_NUM_W-1:0]          miss_cnt_i,
   input  logic                          req_axis_tready_i,
   output logic                          req_axis_tvalid_o,
   output logic [AXI_DATA_W-1:0]         req_axis_tdata_o,
   output logic [AXI_KEEP_W-1:0]         req_axis_tkeep_o,
   output logic                          req_axis_tlast_o,
   output logic                          busy_o,
   output logic                          drop_v_o,
   output logic [$clog2(FIFO_DEPTH):0]   pending_o
);

   // The end-of-session count must never go out as a request count.
   localparam logic [ML_W-1:0] CHUNK_MAX  = (MAX_REQ_CNT == MOLD_EOS_CNT) ? ML_W'(MOLD_EOS_CNT - 1'b1) : ML_W'(MAX_REQ_CNT);
   localparam int              LAST_BYTES = MOLD_REQ_BYTES - 2 * (AXI_DATA_W / 8);

   req_fsm_t                  r_state;
   req_fsm_t                  w_state_nxt;
   logic [SID_W-1:0]          r_sid;
   logic [SEQ_NUM_W-1:0]      r_seq;
   logic [SEQ_NUM_W-1:0]      r_rem;
   logic [GAP_W-1:0]          r_gap;
   logic                      r_flush_pend;
   logic                      r_drop;
   miss_entry_t               w_push_data;
   miss_entry_t               w_head;
   logic                      w_push;
   logic                      w_fifo_wr;
   logic                      w_pop;
   logic                      w_full;
   logic                      w_empty;
   logic [ML_W-1:0]           w_chunk;
   logic                      w_last_hs;

   assign w_push      = miss_v_i & (miss_cnt_i != '0) & ~flush_i;
   assign w_fifo_wr   = w_push & (~w_full | w_pop);
   assign w_push_data = {miss_sid_i, miss_seq_start_i, miss_cnt_i};
   assign w_chunk     = (r_rem > SEQ_NUM_W'(CHUNK_MAX)) ? CHUNK_MAX : r_rem[ML_W-1:0];
   assign w_last_hs   = (r_state == B2) & req_axis_tready_i;
   assign busy_o      = (r_state != IDLE) | ~w_empty;
   assign drop_v_o    = r_drop;

   mold_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_flush (flush_i),
      .i_push  (w_fifo_wr),
      .i_data  (w_push_data),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (pending_o)
   );

   // IDLE looks at an incoming push too, so the pop lands one cycle after the report.
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      case (r_state)
         IDLE: if (en_i & ~flush_i & (r_gap == '0) & (~w_empty | w_push)) w_state_nxt = LOAD;
         LOAD: begin
            if (~flush_i & ~w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = B0;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         B0:   if (req_axis_tready_i) w_state_nxt = B1;
         B1:   if (req_axis_tready_i) w_state_nxt = B2;
         B2:   if (req_axis_tready_i) w_state_nxt = GAP;
         GAP:  if (r_gap <= GAP_W'(1)) w_state_nxt = ((r_rem != '0) & ~flush_i) ? B0 : IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_axis_tvalid_o = 1'b0;
      req_axis_tdata_o  = '0;
      req_axis_tkeep_o  = '0;
      req_axis_tlast_o  = 1'b0;
      case (r_state)
         B0: begin
            req_axis_tvalid_o = 1'b1;
            req_axis_tdata_o  = mold_wire_order(r_sid[SID_W-1 -: 64]);
            req_axis_tkeep_o  = '1;
         end
         B1: begin
            req_axis_tvalid_o = 1'b1;
            req_axis_tdata_o  = mold_wire_order({r_sid[15:0], r_seq[SEQ_NUM_W-1 -: 48]});
            req_axis_tkeep_o  = '1;
         end
         B2: begin
            req_axis_tvalid_o = 1'b1;
            req_axis_tdata_o  = mold_wire_order({r_seq[15:0], w_chunk, 32'h0});
            req_axis_tkeep_o  = AXI_KEEP_W'((1 << LAST_BYTES) - 1);
            req_axis_tlast_o  = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_gap        <= '0;
         r_flush_pend <= 1'b0;
         r_drop       <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_drop  <= w_push & w_full & ~w_pop;
         if (w_last_hs)
            r_gap <= GAP_W'(GAP_CYC);
         else if ((r_state == GAP) && (r_gap != '0))
            r_gap <= r_gap - 1'b1;
         if (w_last_hs)
            r_flush_pend <= 1'b0;
         else if (flush_i && (r_state inside {B0, B1, B2}))
            r_flush_pend <= 1'b1;
      end
   end

   // A flush never truncates a packet; it only cancels the split chunks after it.
   always_ff @(posedge clk) begin
      if (w_pop) begin
         r_sid <= w_head.sid;
         r_seq <= w_head.seq_start;
         r_rem <= w_head.cnt;
      end else if (w_last_hs) begin
         r_seq <= r_seq + SEQ_NUM_W'(w_chunk);
         r_rem <= (flush_i | r_flush_pend) ? '0 : r_rem - SEQ_NUM_W'(w_chunk);
      end else if (flush_i && (r_state == GAP)) begin
         r_rem <= '0;
      end
   end

endmodule

// File: tb/tb_mold_rerequest_sched.sv
// Directed bench for mold_rerequest_sched: packet bytes, split/gap timing,
// queue overflow, stall stability, flush and sequence wrap.
module tb_mold_rerequest_sched;

   localparam int GAP_CYC = 1024;

   logic        clk;
   logic        reset;
   logic        en_i;
   logic        flush_i;
   logic        miss_v_i;
   logic [79:0] miss_sid_i;
   logic [63:0] miss_seq_start_i;
   logic [63:0] miss_cnt_i;
   logic        req_axis_tready_i;
   logic        req_axis_tvalid_o;
   logic [63:0] req_axis_tdata_o;
   logic [7:0]  req_axis_tkeep_o;
   logic        req_axis_tlast_o;
   logic        busy_o;
   logic        drop_v_o;
   logic [2:0]  pending_o;

   mold_rerequest_sched #(.GAP_CYC(GAP_CYC)) dut (
      .clk               (clk),
      .reset             (reset),
      .en_i              (en_i),
      .flush_i           (flush_i),
      .miss_v_i          (miss_v_i),
      .miss_sid_i        (miss_sid_i),
      .miss_seq_start_i  (miss_seq_start_i),
      .miss_cnt_i        (miss_cnt_i),
      .req_axis_tready_i (req_axis_tready_i),
      .req_axis_tvalid_o (req_axis_tvalid_o),
      .req_axis_tdata_o  (req_axis_tdata_o),
      .req_axis_tkeep_o  (req_axis_tkeep_o),
      .req_axis_tlast_o  (req_axis_tlast_o),
      .busy_o            (busy_o),
      .drop_v_o          (drop_v_o),
      .pending_o         (pending_o)
   );

   typedef struct {
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
      int          c;
   } beat_t;

   beat_t       mon_q[$];
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          drop_cnt = 0;
   bit          stab_en = 0;
   bit          prev_stall = 0;
   logic [63:0] prev_d;
   logic [7:0]  prev_k;
   logic        prev_l;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (req_axis_tvalid_o && req_axis_tready_i)
         mon_q.push_back('{d: req_axis_tdata_o, k: req_axis_tkeep_o, l: req_axis_tlast_o, c: cyc});
      if (drop_v_o) drop_cnt++;
      if (stab_en) begin
         if (prev_stall) begin
            chk("t4_stall_valid", req_axis_tvalid_o, 1'b1);
            chk("t4_stall_data", req_axis_tdata_o, prev_d);
            chk("t4_stall_keep", req_axis_tkeep_o, prev_k);
            chk("t4_stall_last", req_axis_tlast_o, prev_l);
         end
         prev_stall = req_axis_tvalid_o & ~req_axis_tready_i;
         prev_d     = req_axis_tdata_o;
         prev_k     = req_axis_tkeep_o;
         prev_l     = req_axis_tlast_o;
      end else begin
         prev_stall = 1'b0;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic drive_miss(input logic v, input logic [79:0] s, input logic [63:0] q,
                             input logic [63:0] c, output int t);
      @(posedge clk);
      #1;
      miss_v_i         = v;
      miss_sid_i       = s;
      miss_seq_start_i = q;
      miss_cnt_i       = c;
      t                = cyc;
   endtask

   task automatic expect_pkt(input string tag, input logic [79:0] sid, input logic [63:0] seq,
                             input logic [15:0] cnt, input int bound,
                             output int first_c, output int last_c);
      logic [7:0]  b [20];
      logic [63:0] exp_d;
      int          waited = 0;
      beat_t       bt;
      for (int i = 0; i < 10; i++) b[i] = sid[79-8*i -: 8];
      for (int i = 0; i < 8; i++)  b[10+i] = seq[63-8*i -: 8];
      b[18] = cnt[15:8];
      b[19] = cnt[7:0];
      first_c = -1;
      last_c  = -1;
      while (mon_q.size() < 3 && waited < bound) begin
         @(negedge clk);
         #1;
         waited++;
      end
      if (mon_q.size() < 3) begin
         chk({tag, "_timeout_beats"}, mon_q.size(), 3);
         return;
      end
      for (int j = 0; j < 3; j++) begin
         bt = mon_q.pop_front();
         exp_d = '0;
         for (int k = 0; k < 8; k++)
            if (8*j + k < 20) exp_d[8*k +: 8] = b[8*j + k];
         chk($sformatf("%s_b%0d_data", tag, j), bt.d, exp_d);
         chk($sformatf("%s_b%0d_keep", tag, j), bt.k, (j < 2) ? 8'hFF : 8'h0F);
         chk($sformatf("%s_b%0d_last", tag, j), bt.l, (j == 2));
         if (j == 0) first_c = bt.c;
         if (j == 2) last_c = bt.c;
      end
   endtask

   task automatic wait_idle(input string tag, input int bound);
      int waited = 0;
      while (busy_o && waited < bound) begin
         @(negedge clk);
         #1;
         waited++;
      end
      chk(tag, busy_o, 1'b0);
   endtask

   initial begin : main
      int t0, t1, f1, l1, f2, l2;
      beat_t bt;
      bit done;
      reset = 1'b1;
      en_i = 1'b0;
      flush_i = 1'b0;
      miss_v_i = 1'b0;
      miss_sid_i = '0;
      miss_seq_start_i = '0;
      miss_cnt_i = '0;
      req_axis_tready_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_tvalid", req_axis_tvalid_o, 1'b0);
      chk("rst_tdata", req_axis_tdata_o, 64'h0);
      chk("rst_tkeep", req_axis_tkeep_o, 8'h0);
      chk("rst_tlast", req_axis_tlast_o, 1'b0);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_drop", drop_v_o, 1'b0);
      chk("rst_pending", pending_o, 3'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      en_i = 1'b1;
      req_axis_tready_i = 1'b1;

      // Test 1: single short range, hand-computed beats
      drive_miss(1'b1, 80'h0123_4567_89AB_CDEF_89AB, 64'd100, 64'd5, t0);
      drive_miss(1'b0, '0, '0, '0, t1);
      begin
         int waited = 0;
         while (mon_q.size() < 3 && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
         end
      end
      chk("t1_beats", mon_q.size(), 3);
      if (mon_q.size() >= 3) begin
         bt = mon_q.pop_front();
         chk("t1_b0_cycle", bt.c, t0 + 2);
         chk("t1_b0_data", bt.d, 64'hEFCD_AB89_6745_2301);
         bt = mon_q.pop_front();
         chk("t1_b1_cycle", bt.c, t0 + 3);
         chk("t1_b1_data", bt.d, 64'h0000_0000_0000_AB89);
         bt = mon_q.pop_front();
         chk("t1_b2_cycle", bt.c, t0 + 4);
         chk("t1_b2_data", bt.d, 64'h0000_0000_0500_6400);
         chk("t1_b2_keep", bt.k, 8'h0F);
         chk("t1_b2_last", bt.l, 1'b1);
      end
      wait_idle("t1_idle", 2000);
      chk("t1_no_extra", mon_q.size(), 0);

      // Test 2: split into 0xFFFE + 2, gap timing
      drive_miss(1'b1, 80'hA1A2_A3A4_A5A6_A7A8_A9AA, 64'd100, 64'h1_0000, t0);
      drive_miss(1'b0, '0, '0, '0, t1);
      expect_pkt("t2_p1", 80'hA1A2_A3A4_A5A6_A7A8_A9AA, 64'd100, 16'hFFFE, 100, f1, l1);
      chk("t2_p1_latency", f1, t0 + 2);
      expect_pkt("t2_p2", 80'hA1A2_A3A4_A5A6_A7A8_A9AA, 64'h1_0062, 16'h0002, 3000, f2, l2);
      chk("t2_gap", f2 - l1, GAP_CYC + 1);
      wait_idle("t2_idle", 2000);
      chk("t2_no_extra", mon_q.size(), 0);

      // Test 3: zero-count discard, overflow drop, flush with simultaneous report
      en_i = 1'b0;
      req_axis_tready_i = 1'b0;
      drive_miss(1'b1, 80'h1, 64'd7, 64'd0, t0);
      drive_miss(1'b0, '0, '0, '0, t1);
      repeat (2) @(negedge clk);
      chk("t3_zero_cnt_pending", pending_o, 3'd0);
      drop_cnt = 0;
      for (int i = 0; i < 5; i++) drive_miss(1'b1, 80'h55, 64'(i * 10 + 1), 64'd3, t0);
      drive_miss(1'b0, '0, '0, '0, t1);
      repeat (3) @(negedge clk);
      chk("t3_drop_pulses", drop_cnt, 1);
      chk("t3_pending_full", pending_o, 3'd4);
      chk("t3_busy", busy_o, 1'b1);
      chk("t3_no_tvalid", req_axis_tvalid_o, 1'b0);
      @(posedge clk);
      #1;
      flush_i = 1'b1;
      miss_v_i = 1'b1;
      miss_cnt_i = 64'd4;
      @(posedge clk);
      #1;
      flush_i = 1'b0;
      miss_v_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("t3_flush_pending", pending_o, 3'd0);
      chk("t3_flush_no_drop", drop_cnt, 1);
      chk("t3_flush_idle", busy_o, 1'b0);

      // Test 4: random tready, stalled beats must hold
      en_i = 1'b1;
      drive_miss(1'b1, 80'h3333_4444_5555_6666_7777, 64'h1111_2222_3333_4444, 64'd7, t0);
      drive_miss(1'b1, 80'h8888_9999_AAAA_BBBB_CCCC, 64'hAAAA_BBBB_CCCC_DDDD, 64'd9, t0);
      drive_miss(1'b0, '0, '0, '0, t1);
      done = 1'b0;
      stab_en = 1'b1;
      fork
         begin
            expect_pkt("t4_a", 80'h3333_4444_5555_6666_7777, 64'h1111_2222_3333_4444, 16'd7, 500, f1, l1);
            expect_pkt("t4_b", 80'h8888_9999_AAAA_BBBB_CCCC, 64'hAAAA_BBBB_CCCC_DDDD, 16'd9, 3000, f2, l2);
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               req_axis_tready_i = ($urandom_range(0, 2) != 0);
            end
         end
      join
      stab_en = 1'b0;
      req_axis_tready_i = 1'b1;
      wait_idle("t4_idle", 2000);

      // Test 5: flush during B1 of a split range
      drive_miss(1'b1, 80'h5555_0000_0000_0000_0005, 64'd500, 64'h2_0000, t0);
      drive_miss(1'b1, 80'h6666_0000_0000_0000_0006, 64'd900, 64'd3, t1);
      drive_miss(1'b0, '0, '0, '0, t1);
      begin
         int waited = 0;
         while (!req_axis_tvalid_o && waited < 50) begin
            @(negedge clk);
            waited++;
         end
      end
      chk("t5_started", req_axis_tvalid_o, 1'b1);
      chk("t5_pending_before", pending_o, 3'd1);
      @(posedge clk);
      #1;
      flush_i = 1'b1;
      @(posedge clk);
      #1;
      flush_i = 1'b0;
      chk("t5_pending_after", pending_o, 3'd0);
      expect_pkt("t5_p1", 80'h5555_0000_0000_0000_0005, 64'd500, 16'hFFFE, 100, f1, l1);
      wait_idle("t5_idle", 2000);
      repeat (20) @(negedge clk);
      chk("t5_no_more", mon_q.size(), 0);
      chk("t5_pending_end", pending_o, 3'd0);

      // Test 6: sequence wrap across a split
      drive_miss(1'b1, 80'h7777_0000_0000_0000_0007, 64'hFFFF_FFFF_FFFF_FFFE, 64'h1_0003, t0);
      drive_miss(1'b0, '0, '0, '0, t1);
      expect_pkt("t6_p1", 80'h7777_0000_0000_0000_0007, 64'hFFFF_FFFF_FFFF_FFFE, 16'hFFFE, 100, f1, l1);
      begin
         int waited = 0;
         while (mon_q.size() < 3 && waited < 3000) begin
            @(negedge clk);
            #1;
            waited++;
         end
      end
      chk("t6_p2_beats", mon_q.size(), 3);
      if (mon_q.size() >= 3) begin
         bt = mon_q.pop_front();
         chk("t6_p2_b0", bt.d, 64'h0000_0000_0000_7777);
         bt = mon_q.pop_front();
         chk("t6_p2_b1", bt.d, 64'h0000_0000_0000_0700);
         bt = mon_q.pop_front();
         chk("t6_p2_b2", bt.d, 64'h0000_0000_0500_FCFF);
         chk("t6_p2_last", bt.l, 1'b1);
      end
      wait_idle("t6_idle", 2000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
